// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: holds committed stores in program order, drains them
// one at a time to data memory, and offers store-to-load forwarding to loads.
module store_commit_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_valid,
  output logic                    commit_ready,
  input  logic [ADDR_WIDTH-1:0]   commit_addr,
  input  logic [DATA_WIDTH-1:0]   commit_data,
  input  logic [2:0]              commit_funct3,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [ADDR_WIDTH-1:0]   fwd_addr,
  input  logic [2:0]              fwd_funct3,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    fwd_stall,
  output logic                    empty
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  function automatic logic [STRB_W-1:0] strb_of(input logic [1:0] offs,
                                                 input logic [1:0] size);
    case (size)
      2'd0:    strb_of = STRB_W'(1) << offs;
      2'd1:    strb_of = STRB_W'(3) << {offs[1], 1'b0};
      default: strb_of = '1;
    endcase
  endfunction

  // Entry storage
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [1:0]            size_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count;
  state_e           state_q, state_d;
  logic             fifo_empty, full, push, pop;
  logic [IDX_W-1:0] head_idx;
  logic [ADDR_WIDTH-1:0] head_addr;

  logic             unused_bits;
  assign unused_bits = ^{commit_funct3[2], fwd_funct3[2]};

  assign head_idx   = head_q[IDX_W-1:0];
  assign head_addr  = addr_q[head_idx];
  assign count      = tail_q - head_q;
  assign fifo_empty = (head_q == tail_q);
  assign full       = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                      (head_q[IDX_W] != tail_q[IDX_W]);
  assign commit_ready = !full;
  // A pop on a full cycle still refuses the push: readiness looks only at state.
  assign push = commit_valid && !full;
  assign pop  = (state_q == S_WAIT) && mem_ack;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: entry storage has no reset; pointers alone decide which slots are valid,
  // and leaving the array unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q[IDX_W-1:0]] <= commit_addr;
      data_q[tail_q[IDX_W-1:0]] <= commit_data;
      size_q[tail_q[IDX_W-1:0]] <= commit_funct3[1:0];
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Drain FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_ack) state_d = (count > PTR_W'(1) || push) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drain FSM: outputs. Head fields cannot change before the ack pops the head.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    if (state_q == S_REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = {head_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata     = data_q[head_idx] << {head_addr[1:0], 3'b000};
      mem_wstrb     = strb_of(head_addr[1:0], size_q[head_idx]);
    end
  end

  assign empty = fifo_empty && (state_q == S_IDLE);

  // Forwarding: walk oldest to youngest so the youngest overlapping store wins.
  logic [STRB_W-1:0]     load_strb;
  logic [IDX_W-1:0]      scan_idx;
  logic                  ovl_found, ovl_exact;
  logic [DATA_WIDTH-1:0] ovl_data;

  assign load_strb = strb_of(fwd_addr[1:0], fwd_funct3[1:0]);

  always_comb begin
    scan_idx  = '0;
    ovl_found = 1'b0;
    ovl_exact = 1'b0;
    ovl_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + IDX_W'(k);
      if ((PTR_W'(k) < count) &&
          (addr_q[scan_idx][ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2]) &&
          ((strb_of(addr_q[scan_idx][1:0], size_q[scan_idx]) & load_strb) != '0)) begin
        ovl_found = 1'b1;
        ovl_exact = (addr_q[scan_idx] == fwd_addr) &&
                    (size_q[scan_idx] == fwd_funct3[1:0]);
        ovl_data  = data_q[scan_idx];
      end
    end
  end

  assign fwd_hit   = ovl_found && ovl_exact;
  assign fwd_stall = ovl_found && !ovl_exact;
  assign fwd_data  = fwd_hit ? ovl_data : '0;

endmodule
